// File: rtl/scratch_pad_arbiter_pkg.sv
// Shared defaults, operation encoding and index-width helper for the scratch-pad arbiter.
package scratch_pad_arbiter_pkg;

   localparam int unsigned DEF_PORTS       = 8;
   localparam int unsigned DEF_WIDTH       = 32;
   localparam int unsigned DEF_ADDR_WIDTH  = 9;
   localparam int unsigned DEF_MEM_LATENCY = 1;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // Bits needed to name one of n ports; never less than one.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scratch_pad_arbiter_if.sv
// Port-side request/response bus and fragment-side memory strobes of the scratch-pad arbiter.
interface scratch_pad_arbiter_if
   import scratch_pad_arbiter_pkg::*;
#(
   parameter int unsigned PORTS      = DEF_PORTS,
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic [0:PORTS-1]            rd_en;
   logic [0:PORTS-1]            wr_en;
   logic [PORTS*ADDR_WIDTH-1:0] addr;
   logic [PORTS*WIDTH-1:0]      d;
   logic [0:PORTS-1]            full;
   logic [PORTS*WIDTH-1:0]      q;
   logic [0:PORTS-1]            valid;
   logic [0:PORTS-1]            stall;
   logic                        mem_rd_en;
   logic                        mem_wr_en;
   logic [ADDR_WIDTH-1:0]       mem_addr;
   logic [WIDTH-1:0]            mem_d;
   logic [WIDTH-1:0]            mem_q;

   modport master (
      output rd_en, wr_en, addr, d, stall, mem_q,
      input  full, q, valid, mem_rd_en, mem_wr_en, mem_addr, mem_d
   );

   modport slave (
      input  rd_en, wr_en, addr, d, stall, mem_q,
      output full, q, valid, mem_rd_en, mem_wr_en, mem_addr, mem_d
   );

endinterface

// File: rtl/scratch_pad_arbiter_rr_arbiter.sv
// Round-robin single-grant picker: first requester at or after ptr, pointer advances past the winner.
module scratch_pad_arbiter_rr_arbiter
   import scratch_pad_arbiter_pkg::*;
#(
   parameter  int unsigned PORTS = DEF_PORTS,
   localparam int unsigned IW    = idx_bits(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] req,
   output logic [PORTS-1:0] gnt_c,
   output logic             gnt_any_c,
   output logic [IW-1:0]    gnt_idx_c
);

   logic [IW-1:0] ptr;
   logic [IW:0]   cand;

   // Scan PORTS candidates starting at ptr, wrapping PORTS-1 -> 0.
   always_comb begin
      gnt_c     = '0;
      gnt_any_c = 1'b0;
      gnt_idx_c = '0;
      cand      = '0;
      for (int unsigned o = 0; o < PORTS; o++) begin
         cand = {1'b0, ptr} + (IW+1)'(o);
         if (cand >= (IW+1)'(PORTS)) cand = cand - (IW+1)'(PORTS);
         if (!gnt_any_c && req[cand[IW-1:0]]) begin
            gnt_any_c = 1'b1;
            gnt_idx_c = cand[IW-1:0];
         end
      end
      gnt_c[gnt_idx_c] = gnt_any_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (gnt_any_c) begin
         ptr <= (gnt_idx_c == IW'(PORTS-1)) ? '0 : gnt_idx_c + IW'(1);
      end
   end

endmodule

// File: rtl/scratch_pad_arbiter.sv
// Multi-port arbiter onto a single scratch-pad fragment: per-port hold register,
// round-robin grant, tag pipeline steering read data back to the requesting port.
module scratch_pad_arbiter
   import scratch_pad_arbiter_pkg::*;
#(
   parameter int unsigned PORTS       = DEF_PORTS,
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
   input logic                   clk,
   input logic                   rst,
   scratch_pad_arbiter_if.slave  bus
);

   localparam int unsigned IW = idx_bits(PORTS);

   op_e                   hold_op   [PORTS];
   logic [ADDR_WIDTH-1:0] hold_addr [PORTS];
   logic [WIDTH-1:0]      hold_d    [PORTS];
   logic [WIDTH-1:0]      q_r       [PORTS];
   logic [IW-1:0]         tag_id    [MEM_LATENCY+1];
   logic [MEM_LATENCY:0]  tag_vld;
   logic [PORTS-1:0]      hold_valid, rd_out, eligible, gnt, accept, valid_r;
   logic                  gnt_any, gnt_rd;
   logic [IW-1:0]         gnt_idx;

   // A held read waits until the port's previous read has been consumed.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < PORTS; i++) begin
         eligible[i] = hold_valid[i] & ((hold_op[i] == OP_WR) | ~rd_out[i]);
      end
   end

   scratch_pad_arbiter_rr_arbiter #(.PORTS(PORTS)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req       (eligible),
      .gnt_c     (gnt),
      .gnt_any_c (gnt_any),
      .gnt_idx_c (gnt_idx)
   );

   assign gnt_rd = gnt_any & (hold_op[gnt_idx] == OP_RD);

   // full depends only on registered state and the grant, never on this cycle's request.
   always_comb begin
      bus.full = '0;
      accept   = '0;
      for (int i = 0; i < PORTS; i++) begin
         bus.full[i] = hold_valid[i] & ~gnt[i] & ~rst;
         accept[i]   = (bus.rd_en[i] | bus.wr_en[i]) & ~(hold_valid[i] & ~gnt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= '0;
         for (int i = 0; i < PORTS; i++) begin
            hold_op[i]   <= OP_RD;
            hold_addr[i] <= '0;
            hold_d[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (accept[i]) begin
               hold_valid[i] <= 1'b1;
               hold_op[i]    <= bus.wr_en[i] ? OP_WR : OP_RD;
               hold_addr[i]  <= bus.addr[(PORTS-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
               hold_d[i]     <= bus.d[(PORTS-1-i)*WIDTH +: WIDTH];
            end else if (gnt[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Fragment strobes pulse for one cycle per grant; address and data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_rd_en <= 1'b0;
         bus.mem_wr_en <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_d     <= '0;
      end else begin
         bus.mem_rd_en <= gnt_rd;
         bus.mem_wr_en <= gnt_any & ~gnt_rd;
         if (gnt_any) begin
            bus.mem_addr <= hold_addr[gnt_idx];
            bus.mem_d    <= hold_d[gnt_idx];
         end
      end
   end

   // Stage MEM_LATENCY lines up with mem_q; capture happens on the following edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld <= '0;
         for (int j = 0; j <= MEM_LATENCY; j++) tag_id[j] <= '0;
      end else begin
         tag_vld[0] <= gnt_rd;
         tag_id[0]  <= gnt_idx;
         for (int j = 1; j <= MEM_LATENCY; j++) begin
            tag_vld[j] <= tag_vld[j-1];
            tag_id[j]  <= tag_id[j-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_out  <= '0;
         valid_r <= '0;
         for (int i = 0; i < PORTS; i++) q_r[i] <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (gnt[i] && hold_op[i] == OP_RD) begin
               rd_out[i] <= 1'b1;
            end else if (valid_r[i] && !bus.stall[i]) begin
               rd_out[i] <= 1'b0;
            end
            if (valid_r[i] && !bus.stall[i]) valid_r[i] <= 1'b0;
         end
         if (tag_vld[MEM_LATENCY]) begin
            valid_r[tag_id[MEM_LATENCY]] <= 1'b1;
            q_r[tag_id[MEM_LATENCY]]     <= bus.mem_q;
         end
      end
   end

   always_comb begin
      bus.valid = '0;
      bus.q     = '0;
      for (int i = 0; i < PORTS; i++) begin
         bus.valid[i]                     = valid_r[i];
         bus.q[(PORTS-1-i)*WIDTH +: WIDTH] = q_r[i] & {WIDTH{~rst}};
      end
   end

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// Scoreboard bench: stimulus pushes gold read data per port, a negedge monitor pops on consumption.
module tb_scratch_pad_arbiter;

   localparam int unsigned P  = 8;
   localparam int unsigned W  = 32;
   localparam int unsigned AW = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scratch_pad_arbiter_if #(.PORTS(P), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

   scratch_pad_arbiter #(.PORTS(P), .WIDTH(W), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] ram  [2**AW] = '{default: '0};
   logic [W-1:0] gold [2**AW] = '{default: '0};
   logic [W-1:0] exp_q [P][$];
   logic [W-1:0] mon_e;

   // Fragment model: one-cycle read latency after the registered strobe.
   always @(posedge clk) begin
      if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_d;
      if (bus.mem_rd_en) bus.mem_q <= ram[bus.mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] q_of(input int p);
      return bus.q[(P-1-p)*W +: W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rd_en = '0;
      bus.wr_en = '0;
      bus.stall = '0;
      bus.addr  = '0;
      bus.d     = '0;
   endtask

   task automatic set_req(input int p, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] dd);
      bus.rd_en[p]               = !wr;
      bus.wr_en[p]               = wr;
      bus.addr[(P-1-p)*AW +: AW] = a;
      bus.d[(P-1-p)*W +: W]      = dd;
   endtask

   // Gold memory is updated in acceptance order; reads snapshot it at acceptance.
   task automatic model_accept(input int p, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] dd);
      if (wr) gold[a] = dd;
      else    exp_q[p].push_back(gold[a]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      for (int p = 0; p < P; p++) exp_q[p].delete();
      chk("post_rst_full", bus.full, 0);
      chk("post_rst_q", |bus.q, 0);
   endtask

   // Data is consumed on the edge after a negedge that sees valid & !stall.
   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < P; p++) begin
            if (bus.valid[p] && !bus.stall[p]) begin
               if (exp_q[p].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_valid port=%0d actual_q=%0h required=none", p, q_of(p));
               end else begin
                  mon_e = exp_q[p].pop_front();
                  chk($sformatf("rdata_p%0d", p), q_of(p), mon_e);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int                 rdcnt;
      int                 vbad;
      int                 ga [$];
      logic [0:P-1]       ef;
      bit                 wr;
      logic [AW-1:0]      a;
      logic [W-1:0]       dd;

      idle();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_full", bus.full, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_q", |bus.q, 0);
      chk("rst_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 0);
      rst = 1'b0;
      chk("post_rst_full", bus.full, 0);
      chk("post_rst_q", |bus.q, 0);

      // Single write then read on port 0 with latency checks.
      set_req(0, 1'b1, 9'd5, 32'd42);
      model_accept(0, 1'b1, 9'd5, 32'd42);
      tick();
      idle();
      chk("wr_not_yet", bus.mem_wr_en, 0);
      tick();
      chk("wr_strobe", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_d}, {1'b1, 1'b0, 9'd5, 32'd42});
      tick();
      chk("wr_one_cycle", bus.mem_wr_en, 0);
      set_req(0, 1'b0, 9'd5, 32'd0);
      model_accept(0, 1'b0, 9'd5, 32'd0);
      tick();
      idle();
      chk("rd_no_strobe_T", bus.mem_rd_en, 0);
      tick();
      chk("rd_strobe", {bus.mem_rd_en, bus.mem_addr}, {1'b1, 9'd5});
      tick();
      chk("valid_not_T2", bus.valid[0], 0);
      tick();
      chk("valid_T3", bus.valid[0], 1);
      chk("q_T3", q_of(0), 42);
      tick();
      tick();

      // All ports write at once from reset: grants 0..7 in order.
      do_reset();
      for (int p = 0; p < P; p++) begin
         set_req(p, 1'b1, AW'(16 + p), W'(100 + p));
         model_accept(p, 1'b1, AW'(16 + p), W'(100 + p));
      end
      tick();
      idle();
      for (int g = 0; g < P; g++) begin
         for (int p = 0; p < P; p++) ef[p] = (p > g);
         chk($sformatf("full_g%0d", g), bus.full, ef);
         tick();
         chk($sformatf("grant_g%0d", g), {bus.mem_wr_en, bus.mem_addr}, {1'b1, AW'(16 + g)});
      end
      chk("full_drained", bus.full, 0);

      // Continuous reads on port 3 under stall: a single read in flight.
      set_req(3, 1'b0, 9'd19, 32'd0);
      bus.stall[3] = 1'b1;
      rdcnt = 0;
      for (int c = 0; c < 14; c++) begin
         if (!bus.full[3]) model_accept(3, 1'b0, 9'd19, 32'd0);
         tick();
         if (bus.mem_rd_en) rdcnt++;
      end
      chk("stall_one_read", rdcnt, 1);
      chk("stall_valid_held", bus.valid[3], 1);
      chk("stall_q_held", q_of(3), 103);
      bus.rd_en[3] = 1'b0;
      bus.stall[3] = 1'b0;
      rdcnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.mem_rd_en) rdcnt++;
      end
      chk("release_second_read", rdcnt, 1);
      chk("drain_p3", exp_q[3].size(), 0);

      // Move ptr to 7, then ports 2 and 6 contend continuously.
      do_reset();
      set_req(6, 1'b1, 9'd22, 32'd7);
      model_accept(6, 1'b1, 9'd22, 32'd7);
      tick();
      idle();
      tick();
      chk("ptr7_grant", {bus.mem_wr_en, bus.mem_addr}, {1'b1, 9'd22});
      for (int c = 0; c < 20 && ga.size() < 4; c++) begin
         set_req(2, 1'b1, 9'd40, 32'd200);
         set_req(6, 1'b1, 9'd41, 32'd206);
         if (!bus.full[2]) model_accept(2, 1'b1, 9'd40, 32'd200);
         if (!bus.full[6]) model_accept(6, 1'b1, 9'd41, 32'd206);
         tick();
         if (bus.mem_wr_en) ga.push_back(int'(bus.mem_addr));
      end
      idle();
      repeat (4) tick();
      chk("rr_count", ga.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < ga.size()) chk($sformatf("rr_order_%0d", k), ga[k], (k % 2 == 1) ? 41 : 40);
      end

      // Reset with reads in flight: nothing returns, ptr restarts at 0.
      do_reset();
      for (int p = 0; p < 4; p++) set_req(p, 1'b0, AW'(16 + p), W'(0));
      tick();
      idle();
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vbad = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.valid != '0) vbad++;
      end
      chk("no_valid_after_rst", vbad, 0);
      set_req(5, 1'b1, 9'd55, 32'd555);
      set_req(0, 1'b1, 9'd50, 32'd500);
      model_accept(5, 1'b1, 9'd55, 32'd555);
      model_accept(0, 1'b1, 9'd50, 32'd500);
      tick();
      idle();
      tick();
      chk("ptr0_first", {bus.mem_wr_en, bus.mem_addr}, {1'b1, 9'd50});
      tick();
      chk("then_p5", {bus.mem_wr_en, bus.mem_addr}, {1'b1, 9'd55});
      set_req(5, 1'b0, 9'd55, 32'd0);
      model_accept(5, 1'b0, 9'd55, 32'd0);
      tick();
      idle();
      repeat (6) tick();
      chk("drain_p5", exp_q[5].size(), 0);

      // Random mixed traffic, each port in its own address window.
      for (int cyc = 0; cyc < 1000; cyc++) begin
         for (int p = 0; p < P; p++) begin
            bus.stall[p] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 40) begin
               wr = 1'($urandom_range(0, 1));
               a  = AW'(p * 64 + int'($urandom_range(0, 3)));
               dd = W'($urandom);
               set_req(p, wr, a, dd);
               if (!bus.full[p]) model_accept(p, wr, a, dd);
            end else begin
               bus.rd_en[p] = 1'b0;
               bus.wr_en[p] = 1'b0;
            end
         end
         tick();
      end
      idle();
      repeat (40) tick();
      for (int p = 0; p < P; p++) chk($sformatf("drain_rand_p%0d", p), exp_q[p].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scratch_pad_arbiter.md
SCRATCH_PAD_ARBITER -- requirements
Module: scratch_pad_arbiter

Interface
REQ-001 Parameter PORTS, default 8: number of requesting ports.
REQ-002 Parameter WIDTH, default 32: data word width.
REQ-003 Parameter ADDR_WIDTH, default 9: fragment address width (512-word fragment).
REQ-004 Parameter MEM_LATENCY, default 1: cycles from mem_rd_en registered to mem_q valid.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rd_en  input  [0:PORTS-1]  per-port read request.
REQ-008 wr_en  input  [0:PORTS-1]  per-port write request.
REQ-009 addr  input  PORTS*ADDR_WIDTH  packed addresses; port 0 in the MSB slice.
REQ-010 d  input  PORTS*WIDTH  packed write data; port 0 in the MSB slice.
REQ-011 full  output  [0:PORTS-1]  port cannot accept a request this cycle.
REQ-012 q  output  PORTS*WIDTH  packed read data; port 0 in the MSB slice.
REQ-013 valid  output  [0:PORTS-1]  q slice for that port holds returned read data.
REQ-014 stall  input  [0:PORTS-1]  consumer not taking valid data; q and valid hold.
REQ-015 mem_rd_en, mem_wr_en  output  1 each  registered fragment strobes.
REQ-016 mem_addr  output  ADDR_WIDTH;  mem_d  output  WIDTH;  mem_q  input  WIDTH.

Function
REQ-017 Request accepted on an edge where (rd_en[i] | wr_en[i]) & !full[i]; rd_en & wr_en both high is illegal; write takes precedence.
REQ-018 Accepted request SHALL be stored in a one-entry per-port hold register (op, addr, d).
REQ-019 full[i] = hold_valid[i] & !grant[i]; full SHALL have no combinational path from rd_en/wr_en/addr/d.
REQ-020 Eligible: held write always; held read only if rd_outstanding[i] == 0.
REQ-021 At most one grant per cycle, round-robin: first eligible port at or after pointer ptr, wrapping PORTS-1 -> 0.
REQ-022 After a grant to port k, ptr <= (k+1) mod PORTS; no grant leaves ptr unchanged.
REQ-023 Grant SHALL register mem_rd_en/mem_wr_en, mem_addr, mem_d on the same edge that clears hold_valid[k] (or reloads it with a simultaneous new request).
REQ-024 Read grant SHALL set rd_outstanding[k] and push port id k into a MEM_LATENCY-deep tag shift pipeline.
REQ-025 When the tag emerges, mem_q SHALL be captured into port k's q slice and valid[k] set.
REQ-026 valid[k] & stall[k]: q slice and valid held; valid[k] & !stall[k]: valid cleared and rd_outstanding[k] cleared on that edge.
REQ-027 Uncontended read latency (MEM_LATENCY=1): request edge T, mem_rd_en high after edge T+1, valid high after edge T+3.
REQ-028 Per-port order preserved; cross-port order follows grant order; write then read to same addr from any ports returns new data if the write was granted first.
REQ-029 Idle cycles SHALL drive mem_rd_en = mem_wr_en = 0; mem_addr/mem_d hold last value.

Reset
REQ-030 rst high at an edge SHALL clear hold_valid, rd_outstanding, tag pipeline valid bits, valid, mem_rd_en, mem_wr_en; ptr <= 0.
REQ-031 During and one cycle after reset, full SHALL read 0 and q SHALL read 0.
REQ-032 Reset mid-operation discards all held and in-flight requests; no valid SHALL assert for pre-reset reads.

Structure
REQ-033 log2 helper and PORTS/WIDTH defaults come from the shared include headers; no new package.
REQ-034 One sub-module, rr_arbiter (PORTS-wide round-robin priority pick with pointer), is natural; the rest is inline.

Verification
REQ-035 Single write port 0, addr 5, d 42; then read port 0 addr 5 -> mem_wr_en one cycle, valid[0] after 3 cycles, q port 0 = 42.
REQ-036 All 8 ports write simultaneously from reset -> grants ports 0..7 in order over 8 cycles; full[i] high until granted.
REQ-037 Port 3 continuous reads, stall[3]=1 for 10 cycles -> one outstanding read, valid[3] and q held, no second mem_rd_en for port 3 until stall drops.
REQ-038 Ports 2 and 6 continuously requesting after ptr=7 -> grant order 2,6,2,6; no port starved.
REQ-039 rst asserted with 4 reads in flight -> no valid after reset; ptr = 0; next request granted normally.
REQ-040 Random mixed traffic vs scratch_pad_gold model, 1000 cycles -> every valid q matches per-port FIFO of gold data.
